// File: rtl/instr_fetch_arbiter_pkg.sv
// Shared definitions for the instruction-fetch arbiter: channel ID sizing and
// the registered response packet routed back to a core.
package instr_fetch_arbiter_pkg;

  localparam int MAX_CORES  = 16;
  localparam int MAX_ID_W   = 4;
  localparam int MAX_DATA_W = 64;

  // Channel ID width for n cores; a single core still gets a 1-bit ID.
  function automatic int id_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  typedef struct packed {
    logic [MAX_ID_W-1:0]   id;
    logic [MAX_DATA_W-1:0] data;
  } rsp_pkt_t;

endpackage

// File: rtl/instr_fetch_arbiter_tag_fifo.sv
// In-order FIFO of channel IDs for memory requests still awaiting a response.
// Depth must be a power of two so the pointers wrap naturally.
module tag_fifo #(
  parameter int width_p = 1,
  parameter int depth_p = 4
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     push_i,
  input  logic [width_p-1:0]       data_i,
  input  logic                     pop_i,
  output logic [width_p-1:0]       data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(depth_p):0] count_o
);

  localparam int PtrW = $clog2(depth_p);

  logic [width_p-1:0] r_mem [depth_p];
  logic [PtrW-1:0]    r_wr_ptr;
  logic [PtrW-1:0]    r_rd_ptr;
  logic [PtrW:0]      r_count;
  logic               w_push;
  logic               w_pop;

  assign full_o  = (r_count == (PtrW+1)'(depth_p));
  assign empty_o = (r_count == '0);
  assign count_o = r_count;
  assign data_o  = r_mem[r_rd_ptr];
  assign w_push  = push_i & ~full_o;
  assign w_pop   = pop_i & ~empty_o;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PtrW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PtrW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (PtrW+1)'(1);
        2'b01:   r_count <= r_count - (PtrW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wr_ptr] <= data_i;
  end

endmodule

// File: rtl/instr_fetch_arbiter.sv
// Round-robin arbiter sharing one in-order instruction memory between cores,
// with a tag FIFO that routes each response back to the requesting core.
module instr_fetch_arbiter
  import instr_fetch_arbiter_pkg::*;
#(
  parameter int num_cores_p       = 2,
  parameter int max_outstanding_p = 4,
  parameter int data_width_p      = 32
) (
  input  logic                                      clk_i,
  input  logic                                      reset_i,
  input  logic [num_cores_p-1:0]                    core_valid_i,
  output logic [num_cores_p-1:0]                    core_ready_o,
  input  logic [num_cores_p-1:0][31:0]              core_addr_i,
  output logic [num_cores_p-1:0]                    core_valid_o,
  output logic [num_cores_p-1:0][data_width_p-1:0]  core_rdata_o,
  output logic                                      mem_valid_o,
  input  logic                                      mem_ready_i,
  output logic [31:0]                               mem_addr_o,
  input  logic                                      mem_valid_i,
  input  logic [data_width_p-1:0]                   mem_rdata_i,
  output logic [$clog2(max_outstanding_p):0]        outstanding_o,
  output logic                                      err_o
);

  localparam int IdW = id_width(num_cores_p);

  logic [IdW-1:0] r_rr_ptr;
  logic           r_locked;
  logic [IdW-1:0] r_lock_id;
  logic           r_err;
  logic           r_rsp_valid;
  rsp_pkt_t       r_rsp;

  logic [IdW-1:0] w_hi_id, w_lo_id, w_pick, w_grant, w_rr_next, w_head;
  logic           w_hi_found, w_lo_found;
  logic           w_full, w_empty, w_hs, w_pop;

  // Lowest requester at or above rr_ptr wins; otherwise the lowest below it.
  always_comb begin
    w_hi_id    = '0;
    w_lo_id    = '0;
    w_hi_found = 1'b0;
    w_lo_found = 1'b0;
    for (int c = num_cores_p - 1; c >= 0; c--) begin
      if (core_valid_i[c]) begin
        if (IdW'(c) >= r_rr_ptr) begin
          w_hi_id    = IdW'(c);
          w_hi_found = 1'b1;
        end else begin
          w_lo_id    = IdW'(c);
          w_lo_found = 1'b1;
        end
      end
    end
    w_pick = w_hi_found ? w_hi_id : (w_lo_found ? w_lo_id : r_rr_ptr);
  end

  // Handshakes: a memory request transfers when mem_valid_o & mem_ready_i in
  // the same cycle, and that is the same cycle core_valid_i & core_ready_o of
  // the granted channel. Once valid is offered without ready the grant is
  // locked until the transfer; responses are strobes with no back-pressure.
  assign w_grant     = r_locked ? r_lock_id : w_pick;
  assign mem_valid_o = ~reset_i & (r_locked | (|core_valid_i)) & ~w_full;
  assign w_hs        = mem_valid_o & mem_ready_i;
  assign w_rr_next   = (w_grant == IdW'(num_cores_p - 1)) ? '0 : w_grant + IdW'(1);
  assign w_pop       = mem_valid_i & ~w_empty;
  assign err_o       = r_err;

  always_comb begin
    mem_addr_o   = '0;
    core_ready_o = '0;
    for (int c = 0; c < num_cores_p; c++) begin
      if (IdW'(c) == w_grant) begin
        mem_addr_o      = core_addr_i[c];
        core_ready_o[c] = mem_ready_i & ~w_full & ~reset_i;
      end
    end
  end

  always_comb begin
    for (int c = 0; c < num_cores_p; c++) begin
      core_valid_o[c] = r_rsp_valid & (r_rsp.id == MAX_ID_W'(c));
      core_rdata_o[c] = data_width_p'(r_rsp.data);
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_rr_ptr    <= '0;
      r_locked    <= 1'b0;
      r_lock_id   <= '0;
      r_err       <= 1'b0;
      r_rsp_valid <= 1'b0;
    end else begin
      if (w_hs) r_rr_ptr <= w_rr_next;
      r_locked    <= mem_valid_o & ~mem_ready_i;
      r_lock_id   <= w_grant;
      r_rsp_valid <= w_pop;
      if (mem_valid_i & w_empty) r_err <= 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_pop) begin
      r_rsp.id   <= MAX_ID_W'(w_head);
      r_rsp.data <= MAX_DATA_W'(mem_rdata_i);
    end
  end

  tag_fifo #(
    .width_p (IdW),
    .depth_p (max_outstanding_p)
  ) u_tag_fifo (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .push_i  (w_hs),
    .data_i  (w_grant),
    .pop_i   (w_pop),
    .data_o  (w_head),
    .full_o  (w_full),
    .empty_o (w_empty),
    .count_o (outstanding_o)
  );

endmodule

// File: tb/tb_instr_fetch_arbiter.sv
// Directed cycle-by-cycle bench for instr_fetch_arbiter at default parameters
// (2 cores, 4 outstanding, 32-bit data).
module tb_instr_fetch_arbiter;

  logic             clk = 1'b0;
  logic             reset_i;
  logic [1:0]       core_valid_i;
  logic [1:0]       core_ready_o;
  logic [1:0][31:0] core_addr_i;
  logic [1:0]       core_valid_o;
  logic [1:0][31:0] core_rdata_o;
  logic             mem_valid_o;
  logic             mem_ready_i;
  logic [31:0]      mem_addr_o;
  logic             mem_valid_i;
  logic [31:0]      mem_rdata_i;
  logic [2:0]       outstanding_o;
  logic             err_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  instr_fetch_arbiter dut (
    .clk_i         (clk),
    .reset_i       (reset_i),
    .core_valid_i  (core_valid_i),
    .core_ready_o  (core_ready_o),
    .core_addr_i   (core_addr_i),
    .core_valid_o  (core_valid_o),
    .core_rdata_o  (core_rdata_o),
    .mem_valid_o   (mem_valid_o),
    .mem_ready_i   (mem_ready_i),
    .mem_addr_o    (mem_addr_o),
    .mem_valid_i   (mem_valid_i),
    .mem_rdata_i   (mem_rdata_i),
    .outstanding_o (outstanding_o),
    .err_o         (err_o)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Inputs change just after the rising edge; outputs are checked at the falling edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic drive(input logic rst, input logic [1:0] cv, input logic mr,
                       input logic mv, input logic [31:0] rd);
    reset_i      = rst;
    core_valid_i = cv;
    mem_ready_i  = mr;
    mem_valid_i  = mv;
    mem_rdata_i  = rd;
  endtask

  initial begin
    core_addr_i = '0;
    drive(1'b1, 2'b00, 1'b0, 1'b0, 32'h0);
    repeat (2) next_cycle();

    // Reset cycle with requests present: nothing offered or granted
    drive(1'b1, 2'b11, 1'b1, 1'b0, 32'h0);
    settle();
    chk("rst_mem_valid", mem_valid_o, 0);
    chk("rst_core_ready", core_ready_o, 0);
    next_cycle();
    drive(1'b0, 2'b00, 1'b0, 1'b0, 32'h0);
    settle();
    chk("rst_outstanding", outstanding_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_core_valid", core_valid_o, 0);
    chk("rst_idle_mem_valid", mem_valid_o, 0);
    next_cycle();

    // Two cores streaming, memory always ready, response one cycle after issue
    core_addr_i[0] = 32'h100;
    core_addr_i[1] = 32'h200;
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, 2'b11, 1'b1, k >= 1, 32'hD0 + k - 1);
      settle();
      chk("A_ready", core_ready_o, (k % 2 == 0) ? 2'b01 : 2'b10);
      chk("A_addr", mem_addr_o, (k % 2 == 0) ? 32'h100 : 32'h200);
      chk("A_outstanding", outstanding_o, (k == 0) ? 0 : 1);
      if (k >= 2) begin
        chk("A_rsp_valid", core_valid_o, (k % 2 == 0) ? 2'b01 : 2'b10);
        chk("A_rsp_data", core_rdata_o[k % 2], 32'hD0 + k - 2);
      end else begin
        chk("A_rsp_idle", core_valid_o, 0);
      end
      next_cycle();
    end
    drive(1'b0, 2'b00, 1'b1, 1'b1, 32'hD3);
    settle();
    chk("A_idle_mem_valid", mem_valid_o, 0);
    chk("A_rsp_valid_c4", core_valid_o, 2'b01);
    chk("A_rsp_data_c4", core_rdata_o[0], 32'hD2);
    chk("A_outstanding_c4", outstanding_o, 1);
    next_cycle();
    drive(1'b0, 2'b00, 1'b1, 1'b0, 32'h0);
    settle();
    chk("A_rsp_valid_c5", core_valid_o, 2'b10);
    chk("A_rsp_data_c5", core_rdata_o[1], 32'hD3);
    chk("A_outstanding_c5", outstanding_o, 0);
    next_cycle();
    settle();
    chk("A_rsp_single_pulse", core_valid_o, 0);

    // Stalled memory: core0 keeps the grant while core1 joins
    core_addr_i[0] = 32'h300;
    core_addr_i[1] = 32'h400;
    for (int k = 0; k < 3; k++) begin
      next_cycle();
      drive(1'b0, (k == 2) ? 2'b11 : 2'b01, 1'b0, 1'b0, 32'h0);
      settle();
      chk("B_stall_valid", mem_valid_o, 1);
      chk("B_stall_addr", mem_addr_o, 32'h300);
      chk("B_stall_ready", core_ready_o, 0);
    end
    next_cycle();
    drive(1'b0, 2'b11, 1'b1, 1'b0, 32'h0);
    settle();
    chk("B_first_grant", core_ready_o, 2'b01);
    chk("B_first_addr", mem_addr_o, 32'h300);
    next_cycle();
    drive(1'b0, 2'b10, 1'b1, 1'b0, 32'h0);
    settle();
    chk("B_second_grant", core_ready_o, 2'b10);
    chk("B_second_addr", mem_addr_o, 32'h400);
    next_cycle();

    // Push and pop together at two outstanding; oldest tag (core0) is served
    core_addr_i[0] = 32'h500;
    drive(1'b0, 2'b01, 1'b1, 1'b1, 32'hE0);
    settle();
    chk("C_outstanding_pre", outstanding_o, 2);
    chk("C_ready", core_ready_o, 2'b01);
    next_cycle();
    drive(1'b0, 2'b00, 1'b1, 1'b1, 32'hE1);
    settle();
    chk("C_outstanding_same", outstanding_o, 2);
    chk("C_rsp_valid0", core_valid_o, 2'b01);
    chk("C_rsp_data0", core_rdata_o[0], 32'hE0);
    next_cycle();
    drive(1'b0, 2'b00, 1'b1, 1'b1, 32'hE2);
    settle();
    chk("C_rsp_valid1", core_valid_o, 2'b10);
    chk("C_rsp_data1", core_rdata_o[1], 32'hE1);
    chk("C_outstanding1", outstanding_o, 1);
    next_cycle();
    drive(1'b0, 2'b00, 1'b1, 1'b0, 32'h0);
    settle();
    chk("C_rsp_valid2", core_valid_o, 2'b01);
    chk("C_rsp_data2", core_rdata_o[0], 32'hE2);
    chk("C_outstanding0", outstanding_o, 0);
    next_cycle();

    // Fill to four outstanding; issue stops, and resumes after one response
    core_addr_i[0] = 32'h600;
    core_addr_i[1] = 32'h700;
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, 2'b11, 1'b1, 1'b0, 32'h0);
      settle();
      chk("D_fill_ready", core_ready_o, (k % 2 == 0) ? 2'b10 : 2'b01);
      chk("D_fill_outstanding", outstanding_o, k);
      next_cycle();
    end
    drive(1'b0, 2'b11, 1'b1, 1'b1, 32'hF0);
    settle();
    chk("D_full_outstanding", outstanding_o, 4);
    chk("D_full_mem_valid", mem_valid_o, 0);
    chk("D_full_ready", core_ready_o, 0);
    next_cycle();
    drive(1'b0, 2'b11, 1'b1, 1'b0, 32'h0);
    settle();
    chk("D_resume_outstanding", outstanding_o, 3);
    chk("D_resume_mem_valid", mem_valid_o, 1);
    chk("D_resume_ready", core_ready_o, 2'b10);
    chk("D_resume_rsp_valid", core_valid_o, 2'b10);
    chk("D_resume_rsp_data", core_rdata_o[1], 32'hF0);
    next_cycle();
    for (int j = 0; j < 4; j++) begin
      drive(1'b0, 2'b00, 1'b1, 1'b1, 32'hF1 + j);
      settle();
      chk("D_drain_outstanding", outstanding_o, 4 - j);
      if (j >= 1) begin
        chk("D_drain_rsp_valid", core_valid_o, ((j - 1) % 2 == 0) ? 2'b01 : 2'b10);
        chk("D_drain_rsp_data", core_rdata_o[(j - 1) % 2], 32'hF1 + j - 1);
      end else begin
        chk("D_drain_rsp_idle", core_valid_o, 0);
      end
      next_cycle();
    end
    drive(1'b0, 2'b00, 1'b1, 1'b0, 32'h0);
    settle();
    chk("D_last_rsp_valid", core_valid_o, 2'b10);
    chk("D_last_rsp_data", core_rdata_o[1], 32'hF4);
    chk("D_empty_outstanding", outstanding_o, 0);
    next_cycle();

    // Response with nothing in flight: dropped, sticky error
    drive(1'b0, 2'b00, 1'b1, 1'b1, 32'hBAD);
    settle();
    chk("E_err_before", err_o, 0);
    next_cycle();
    drive(1'b0, 2'b00, 1'b1, 1'b0, 32'h0);
    settle();
    chk("E_no_rsp", core_valid_o, 0);
    chk("E_err_set", err_o, 1);
    chk("E_outstanding", outstanding_o, 0);
    next_cycle();
    settle();
    chk("E_err_sticky", err_o, 1);
    next_cycle();
    drive(1'b1, 2'b00, 1'b0, 1'b0, 32'h0);
    next_cycle();
    drive(1'b0, 2'b00, 1'b0, 1'b0, 32'h0);
    settle();
    chk("E_err_cleared", err_o, 0);
    next_cycle();

    // Reset with three in flight and rr_ptr at core1
    core_addr_i[0] = 32'h800;
    core_addr_i[1] = 32'h900;
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 2'b11, 1'b1, 1'b0, 32'h0);
      settle();
      chk("F_ready", core_ready_o, (k % 2 == 0) ? 2'b01 : 2'b10);
      next_cycle();
    end
    drive(1'b1, 2'b11, 1'b1, 1'b0, 32'h0);
    settle();
    chk("F_pre_outstanding", outstanding_o, 3);
    chk("F_rst_mem_valid", mem_valid_o, 0);
    chk("F_rst_ready", core_ready_o, 0);
    next_cycle();
    drive(1'b0, 2'b11, 1'b0, 1'b0, 32'h0);
    settle();
    chk("F_post_outstanding", outstanding_o, 0);
    chk("F_post_rr_addr", mem_addr_o, 32'h800);
    chk("F_post_mem_valid", mem_valid_o, 1);
    next_cycle();
    drive(1'b0, 2'b00, 1'b0, 1'b1, 32'h55);
    settle();
    next_cycle();
    drive(1'b0, 2'b00, 1'b0, 1'b0, 32'h0);
    settle();
    chk("F_late_err", err_o, 1);
    chk("F_late_no_rsp", core_valid_o, 0);
    chk("F_late_outstanding", outstanding_o, 0);
    next_cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_fetch_arbiter.md
INSTR_FETCH_ARBITER -- requirements
Module: instr_fetch_arbiter

Interface
REQ-001 SHALL have parameter num_cores_p, default 2: number of core instruction channels (1..16).
REQ-002 SHALL have parameter max_outstanding_p, default 4: in-flight memory requests (power of 2, >=2).
REQ-003 SHALL have parameter data_width_p, default 32: instruction word width.
REQ-004 SHALL have port clk_i  in  1  clock. One clock; reset is synchronous and active-high.
REQ-005 SHALL have port reset_i  in  1  synchronous active-high reset.
REQ-006 SHALL have port core_valid_i  in  [num_cores_p]  per-core fetch request.
REQ-007 SHALL have port core_ready_o  out  [num_cores_p]  per-core grant.
REQ-008 SHALL have port core_addr_i  in  [num_cores_p][32]  per-core fetch address.
REQ-009 SHALL have port core_valid_o  out  [num_cores_p]  per-core response strobe.
REQ-010 SHALL have port core_rdata_o  out  [num_cores_p][data_width_p]  per-core response data.
REQ-011 SHALL have port mem_valid_o  out  1  request to shared instruction memory.
REQ-012 SHALL have port mem_ready_i  in  1  memory accepts request.
REQ-013 SHALL have port mem_addr_o  out  32  request address.
REQ-014 SHALL have port mem_valid_i  in  1  in-order memory response strobe.
REQ-015 SHALL have port mem_rdata_i  in  data_width_p  response data.
REQ-016 SHALL have port outstanding_o  out  $clog2(max_outstanding_p)+1  in-flight count.
REQ-017 SHALL have port err_o  out  1  sticky: response received with no request in flight.

Function
REQ-018 SHALL accept a request on a channel when core_valid_i[c] & core_ready_o[c]; mem handshake is mem_valid_o & mem_ready_i in the same cycle.
REQ-019 SHALL select among requesting channels by round-robin: priority starts at rr_ptr, wrapping from num_cores_p-1 to 0.
REQ-020 SHALL, after a handshake by channel g, set rr_ptr to (g+1) mod num_cores_p; rr_ptr is unchanged otherwise.
REQ-021 SHALL lock the grant while mem_valid_o is high without handshake: mem_addr_o and the granted channel stay stable until the handshake, regardless of new requests.
REQ-022 SHALL drive mem_valid_o = (locked | any core_valid_i) & ~full, with mem_addr_o = core_addr_i of the granted channel.
REQ-023 SHALL assert core_ready_o only for the granted channel, equal to mem_ready_i & ~full; all others 0.
REQ-024 SHALL push the granted channel ID into a tag FIFO of depth max_outstanding_p on each handshake.
REQ-025 SHALL deassert mem_valid_o when the FIFO is full, even if a pop occurs in the same cycle.
REQ-026 SHALL pop the FIFO head on mem_valid_i and, one cycle later, pulse core_valid_o[head] for exactly one cycle with core_rdata_o[head] = captured mem_rdata_i.
REQ-027 SHALL hold core_valid_o at 0 on non-target channels; core_rdata_o is don't-care when core_valid_o is low.
REQ-028 SHALL allow push and pop in the same cycle when not full; outstanding_o is unchanged in that case.
REQ-029 SHALL, on mem_valid_i with an empty FIFO, discard the response, leave the FIFO unchanged, assert no core_valid_o, and set err_o until reset.
REQ-030 SHALL keep outstanding_o equal to pushes minus pops, in range 0..max_outstanding_p.

Reset
REQ-031 SHALL, while reset_i is high at a clock edge, clear FIFO pointers, outstanding_o, rr_ptr (to 0), lock state, err_o, and core_valid_o.
REQ-032 SHALL hold mem_valid_o and core_ready_o at 0 during the reset cycle.
REQ-033 SHALL discard in-flight tags on mid-operation reset; responses arriving afterwards follow REQ-029.

Structure
REQ-034 SHALL place the channel ID width ($clog2 of num_cores_p, minimum 1) and the response packet typedef (ID, data) in the shared cache package.
REQ-035 SHALL implement the tag FIFO as the sub-module tag_fifo, parametrised by width and depth, with full/empty outputs.

Verification
REQ-036 Two cores valid continuously, mem_ready_i=1, immediate responses -> grants alternate 0,1,0,1; each core_valid_o arrives 1 cycle after its mem_valid_i.
REQ-037 Core0 valid, mem_ready_i=0 for 3 cycles, core1 raises valid in cycle 2 -> mem_addr_o holds core0 address; core0 is granted first.
REQ-038 max_outstanding_p=4, 4 handshakes, no responses -> outstanding_o=4, mem_valid_o=0; one mem_valid_i -> outstanding_o=3, and issue resumes the next cycle.
REQ-039 Push and pop in the same cycle with outstanding_o=2 -> outstanding_o stays 2; routed response goes to the oldest tag.
REQ-040 mem_valid_i with outstanding_o=0 -> no core_valid_o and err_o=1 until reset_i.
REQ-041 reset_i asserted with 3 in flight -> next cycle outstanding_o=0, rr_ptr=0, and late responses set err_o.
